// File: rtl/dram_read_arb.sv
// Two-port arbiter for the DRAM read command channel: fixed priority to port 0
// with a starvation guard for port 1, and return-beat steering to the owner.
module dram_read_arb #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_kick,
    input  logic [31:0] m0_read_addr,
    input  logic [31:0] m0_read_num,
    output logic        m0_busy,
    output logic [31:0] m0_buf_dout,
    output logic        m0_buf_we,
    input  logic        m1_kick,
    input  logic [31:0] m1_read_addr,
    input  logic [31:0] m1_read_num,
    output logic        m1_busy,
    output logic [31:0] m1_buf_dout,
    output logic        m1_buf_we,
    output logic        kick,
    input  logic        busy,
    output logic [31:0] read_addr,
    output logic [31:0] read_num,
    input  logic [31:0] buf_dout,
    input  logic        buf_we,
    output logic [1:0]  grant,
    output logic        err_overrun
);

    localparam int unsigned AW = 32;
    localparam int unsigned NW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_DATA,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic            pend0_q, pend0_d, pend1_q, pend1_d;
    logic [AW-1:0]   addr0_q, addr0_d, addr1_q, addr1_d;
    logic [NW-1:0]   num0_q, num0_d, num1_q, num1_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic            hold_q, hold_d;
    logic [NW-1:0]   beat_cnt_q, beat_cnt_d;
    logic            kick_q, kick_d;
    logic [1:0]      grant_q, grant_d;
    logic [AW-1:0]   read_addr_q, read_addr_d;
    logic [NW-1:0]   read_num_q, read_num_d;
    logic            m0_busy_q, m0_busy_d, m1_busy_q, m1_busy_d;
    logic            m0_we_q, m0_we_d, m1_we_q, m1_we_d;
    logic [DW-1:0]   m0_dout_q, m0_dout_d, m1_dout_q, m1_dout_d;
    logic            err_q, err_d;
    logic            accept;
    logic            pick1;
    logic [NW-1:0]   sel_num;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pend0_q     <= 1'b0;
            pend1_q     <= 1'b0;
            addr0_q     <= '0;
            addr1_q     <= '0;
            num0_q      <= '0;
            num1_q      <= '0;
            starve_q    <= '0;
            hold_q      <= 1'b1;
            beat_cnt_q  <= '0;
            kick_q      <= 1'b0;
            grant_q     <= 2'b00;
            read_addr_q <= '0;
            read_num_q  <= '0;
            m0_busy_q   <= 1'b0;
            m1_busy_q   <= 1'b0;
            m0_we_q     <= 1'b0;
            m1_we_q     <= 1'b0;
            m0_dout_q   <= '0;
            m1_dout_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend0_q     <= pend0_d;
            pend1_q     <= pend1_d;
            addr0_q     <= addr0_d;
            addr1_q     <= addr1_d;
            num0_q      <= num0_d;
            num1_q      <= num1_d;
            starve_q    <= starve_d;
            hold_q      <= hold_d;
            beat_cnt_q  <= beat_cnt_d;
            kick_q      <= kick_d;
            grant_q     <= grant_d;
            read_addr_q <= read_addr_d;
            read_num_q  <= read_num_d;
            m0_busy_q   <= m0_busy_d;
            m1_busy_q   <= m1_busy_d;
            m0_we_q     <= m0_we_d;
            m1_we_q     <= m1_we_d;
            m0_dout_q   <= m0_dout_d;
            m1_dout_q   <= m1_dout_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pend0_d     = pend0_q;
        pend1_d     = pend1_q;
        addr0_d     = addr0_q;
        addr1_d     = addr1_q;
        num0_d      = num0_q;
        num1_d      = num1_q;
        starve_d    = starve_q;
        hold_d      = hold_q;
        beat_cnt_d  = beat_cnt_q;
        kick_d      = 1'b0;
        grant_d     = grant_q;
        read_addr_d = read_addr_q;
        read_num_d  = read_num_q;
        m0_we_d     = 1'b0;
        m1_we_d     = 1'b0;
        m0_dout_d   = m0_dout_q;
        m1_dout_d   = m1_dout_q;
        err_d       = err_q;
        pick1       = 1'b0;
        sel_num     = '0;

        // Request capture; a busy port cannot re-request.
        if (m0_kick && !m0_busy_q) begin
            pend0_d = 1'b1;
            addr0_d = m0_read_addr;
            num0_d  = m0_read_num;
        end
        if (m1_kick && !m1_busy_q) begin
            pend1_d = 1'b1;
            addr1_d = m1_read_addr;
            num1_d  = m1_read_num;
        end

        // Beat steering; excess or ownerless beats are dropped and flagged,
        // except in the settling IDLE cycle right after DONE or reset.
        accept = buf_we && (grant_q != 2'b00) && (beat_cnt_q != read_num_q);
        if (accept) begin
            beat_cnt_d = beat_cnt_q + NW'(1);
            m0_we_d    = grant_q[0];
            m1_we_d    = grant_q[1];
            if (grant_q[0]) m0_dout_d = buf_dout;
            if (grant_q[1]) m1_dout_d = buf_dout;
        end else if (buf_we && ((grant_q != 2'b00) || !hold_q)) begin
            err_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                beat_cnt_d = '0;
                hold_d     = 1'b0;
                if (!hold_q && (pend0_q || pend1_q)) begin
                    pick1 = pend1_q && (!pend0_q || (starve_q == SW'(STARVE_MAX)));
                    if (pick1) begin
                        grant_d     = 2'b10;
                        read_addr_d = addr1_q;
                        read_num_d  = num1_q;
                        sel_num     = num1_q;
                        pend1_d     = 1'b0;
                        starve_d    = '0;
                    end else begin
                        grant_d     = 2'b01;
                        read_addr_d = addr0_q;
                        read_num_d  = num0_q;
                        sel_num     = num0_q;
                        pend0_d     = 1'b0;
                        if (!pend1_q)
                            starve_d = '0;
                        else if (starve_q != SW'(STARVE_MAX))
                            starve_d = starve_q + SW'(1);
                    end
                    if (sel_num == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                        kick_d  = 1'b1;
                    end
                end
            end
            S_ISSUE:     state_d = S_WAIT_BUSY;
            S_WAIT_BUSY: if (busy) state_d = S_DATA;
            S_DATA:      if (!busy && (beat_cnt_q == read_num_q)) state_d = S_DONE;
            S_DONE: begin
                grant_d = 2'b00;
                hold_d  = 1'b1;
                state_d = S_IDLE;
            end
            default:     state_d = S_IDLE;
        endcase

        m0_busy_d = pend0_d || grant_d[0];
        m1_busy_d = pend1_d || grant_d[1];
    end

    assign kick        = kick_q;
    assign grant       = grant_q;
    assign read_addr   = read_addr_q;
    assign read_num    = read_num_q;
    assign m0_busy     = m0_busy_q;
    assign m1_busy     = m1_busy_q;
    assign m0_buf_we   = m0_we_q;
    assign m1_buf_we   = m1_we_q;
    assign m0_buf_dout = m0_dout_q;
    assign m1_buf_dout = m1_dout_q;
    assign err_overrun = err_q;

endmodule

// File: tb/tb_dram_read_arb.sv
// Directed bench for dram_read_arb: a scripted read engine plus monitors that
// log delivered beats per port and the grant at every kick.
module tb_dram_read_arb;

    logic        clk;
    logic        rst;
    logic        m0_kick, m1_kick;
    logic [31:0] m0_read_addr, m0_read_num, m1_read_addr, m1_read_num;
    logic        m0_busy, m1_busy, m0_buf_we, m1_buf_we;
    logic [31:0] m0_buf_dout, m1_buf_dout;
    logic        kick, busy, buf_we, err_overrun;
    logic [31:0] read_addr, read_num, buf_dout;
    logic [1:0]  grant;

    int checks   = 0;
    int failures = 0;

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [1:0]  glog[$];

    dram_read_arb #(.STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .m0_kick(m0_kick), .m0_read_addr(m0_read_addr), .m0_read_num(m0_read_num),
        .m0_busy(m0_busy), .m0_buf_dout(m0_buf_dout), .m0_buf_we(m0_buf_we),
        .m1_kick(m1_kick), .m1_read_addr(m1_read_addr), .m1_read_num(m1_read_num),
        .m1_busy(m1_busy), .m1_buf_dout(m1_buf_dout), .m1_buf_we(m1_buf_we),
        .kick(kick), .busy(busy), .read_addr(read_addr), .read_num(read_num),
        .buf_dout(buf_dout), .buf_we(buf_we), .grant(grant), .err_overrun(err_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mid-cycle monitor of delivered beats and kick ownership.
    always @(negedge clk) begin
        if (m0_buf_we === 1'b1) q0.push_back(m0_buf_dout);
        if (m1_buf_we === 1'b1) q1.push_back(m1_buf_dout);
        if (kick === 1'b1) glog.push_back(grant);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Engine model: wait for kick, then assert busy and stream beats base+i.
    task automatic engine(input string tag, input int nbeats, input int busy_cyc,
                          input logic [31:0] base);
        int n;
        int total;
        n = 0;
        while (kick !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_kick_seen"}, 32'(kick), 32'd1);
        step();
        total = (busy_cyc > nbeats) ? busy_cyc : nbeats;
        for (int i = 0; i < total; i++) begin
            busy     = (i < busy_cyc);
            buf_we   = (i < nbeats);
            buf_dout = base + 32'(i);
            step();
        end
        busy   = 1'b0;
        buf_we = 1'b0;
    endtask

    initial begin
        int glog_n;
        int hi_cnt;
        rst = 1'b1;
        m0_kick = 1'b0; m1_kick = 1'b0;
        m0_read_addr = '0; m0_read_num = '0;
        m1_read_addr = '0; m1_read_num = '0;
        busy = 1'b0; buf_we = 1'b0; buf_dout = '0;
        step(); step();

        // Reset values
        chk("rst_kick", 32'(kick), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_addr", read_addr, 32'd0);
        chk("rst_num", read_num, 32'd0);
        chk("rst_busy", 32'({m0_busy, m1_busy}), 32'd0);
        chk("rst_we", 32'({m0_buf_we, m1_buf_we}), 32'd0);
        chk("rst_dout", m0_buf_dout | m1_buf_dout, 32'd0);
        chk("rst_err", 32'(err_overrun), 32'd0);
        rst = 1'b0;
        step(); step();

        // Single port-0 read of 4 beats
        q0.delete(); q1.delete();
        m0_kick = 1'b1; m0_read_addr = 32'h100; m0_read_num = 32'd4;
        step();
        m0_kick = 1'b0;
        chk("t1_busy_t1", 32'(m0_busy), 32'd1);
        chk("t1_kick_t1", 32'(kick), 32'd0);
        step();
        chk("t1_kick_t2", 32'(kick), 32'd1);
        chk("t1_addr", read_addr, 32'h100);
        chk("t1_num", read_num, 32'd4);
        chk("t1_grant", 32'(grant), 32'd1);
        engine("t1", 4, 6, 32'hA000);
        chk("t1_busy_b0", 32'(m0_busy), 32'd1);
        step();
        chk("t1_busy_done", 32'(m0_busy), 32'd1);
        m0_kick = 1'b1;
        step();
        m0_kick = 1'b0;
        chk("t1_busy_b2", 32'(m0_busy), 32'd0);
        chk("t1_grant_end", 32'(grant), 32'd0);
        step();
        chk("t1_done_kick_ignored", 32'(m0_busy), 32'd0);
        step(); step();
        chk("t1_no_kick", 32'(kick), 32'd0);
        chk("t1_q0_n", 32'(q0.size()), 32'd4);
        chk("t1_q0_0", q0[0], 32'hA000);
        chk("t1_q0_3", q0[3], 32'hA003);
        chk("t1_q1_n", 32'(q1.size()), 32'd0);
        chk("t1_err", 32'(err_overrun), 32'd0);

        // Simultaneous kicks: port 0 first, then port 1
        q0.delete(); q1.delete(); glog.delete();
        m0_kick = 1'b1; m0_read_addr = 32'h0;   m0_read_num = 32'd2;
        m1_kick = 1'b1; m1_read_addr = 32'h800; m1_read_num = 32'd2;
        step();
        m0_kick = 1'b0; m1_kick = 1'b0;
        chk("t2_m1_busy_a", 32'(m1_busy), 32'd1);
        engine("t2p0", 2, 3, 32'hB000);
        chk("t2_m1_busy_b", 32'(m1_busy), 32'd1);
        engine("t2p1", 2, 3, 32'hC000);
        chk("t2_m1_addr", read_addr, 32'h800);
        chk("t2_m1_busy_c", 32'(m1_busy), 32'd1);
        step(); step();
        chk("t2_m1_busy_end", 32'(m1_busy), 32'd0);
        chk("t2_order0", 32'(glog[0]), 32'd1);
        chk("t2_order1", 32'(glog[1]), 32'd2);
        chk("t2_q0_n", 32'(q0.size()), 32'd2);
        chk("t2_q0_1", q0[1], 32'hB001);
        chk("t2_q1_n", 32'(q1.size()), 32'd2);
        chk("t2_q1_0", q1[0], 32'hC000);
        step(); step();

        // Starvation guard: port 0 re-kicks right after each DONE
        glog.delete();
        m0_kick = 1'b1; m0_read_addr = 32'h40;  m0_read_num = 32'd1;
        m1_kick = 1'b1; m1_read_addr = 32'h900; m1_read_num = 32'd1;
        step();
        m0_kick = 1'b0; m1_kick = 1'b0;
        for (int t = 0; t < 6; t++) begin
            engine("t3", 1, 2, 32'hD000 + 32'(t));
            step(); step();
            if (t < 5 && m0_busy === 1'b0) begin
                m0_kick = 1'b1;
                step();
                m0_kick = 1'b0;
            end
        end
        chk("t3_n", 32'(glog.size()), 32'd6);
        chk("t3_g0", 32'(glog[0]), 32'd1);
        chk("t3_g1", 32'(glog[1]), 32'd1);
        chk("t3_g2", 32'(glog[2]), 32'd1);
        chk("t3_g3", 32'(glog[3]), 32'd1);
        chk("t3_g4", 32'(glog[4]), 32'd2);
        chk("t3_g5", 32'(glog[5]), 32'd1);
        step(); step();

        // Zero-length request on port 1
        glog_n = glog.size();
        hi_cnt = 0;
        m1_kick = 1'b1; m1_read_addr = 32'h1000; m1_read_num = 32'd0;
        step();
        m1_kick = 1'b0;
        if (m1_busy === 1'b1) hi_cnt++;
        step();
        chk("t4_grant", 32'(grant), 32'd2);
        for (int i = 0; i < 4; i++) begin
            if (m1_busy === 1'b1) hi_cnt++;
            step();
        end
        chk("t4_busy_cycles", 32'(hi_cnt), 32'd2);
        chk("t4_no_kick", 32'(glog.size()), 32'(glog_n));
        chk("t4_grant_end", 32'(grant), 32'd0);

        // Overrun: 3 requested, 4 returned
        q0.delete();
        m0_kick = 1'b1; m0_read_addr = 32'h300; m0_read_num = 32'd3;
        step();
        m0_kick = 1'b0;
        engine("t5", 4, 6, 32'hE000);
        step(); step(); step();
        chk("t5_q0_n", 32'(q0.size()), 32'd3);
        chk("t5_q0_2", q0[2], 32'hE002);
        chk("t5_err", 32'(err_overrun), 32'd1);
        step(); step();

        // Reset during DATA after one beat
        q0.delete();
        m0_kick = 1'b1; m0_read_addr = 32'h400; m0_read_num = 32'd4;
        step();
        m0_kick = 1'b0;
        chk("t6_err_held", 32'(err_overrun), 32'd1);
        begin
            int n;
            n = 0;
            while (kick !== 1'b1 && n < 20) begin
                step();
                n++;
            end
        end
        chk("t6_kick_seen", 32'(kick), 32'd1);
        step();
        busy = 1'b1; buf_we = 1'b1; buf_dout = 32'hF000;
        step();
        buf_we = 1'b0;
        step();
        rst = 1'b1; buf_we = 1'b1; buf_dout = 32'hF001;
        step();
        rst = 1'b0; buf_dout = 32'hF002;
        chk("t6_grant", 32'(grant), 32'd0);
        chk("t6_busy", 32'({m0_busy, m1_busy}), 32'd0);
        chk("t6_err_clr", 32'(err_overrun), 32'd0);
        chk("t6_kick", 32'(kick), 32'd0);
        chk("t6_addr", read_addr, 32'd0);
        step();
        busy = 1'b0; buf_we = 1'b0;
        step(); step();
        chk("t6_err_stays", 32'(err_overrun), 32'd0);
        chk("t6_q0_n", 32'(q0.size()), 32'd1);

        // Normal service after reset
        q0.delete();
        m0_kick = 1'b1; m0_read_addr = 32'h200; m0_read_num = 32'd2;
        step();
        m0_kick = 1'b0;
        step();
        chk("t7_kick", 32'(kick), 32'd1);
        chk("t7_addr", read_addr, 32'h200);
        engine("t7", 2, 3, 32'h7000);
        step(); step();
        chk("t7_busy_end", 32'(m0_busy), 32'd0);
        chk("t7_q0_n", 32'(q0.size()), 32'd2);
        chk("t7_q0_1", q0[1], 32'h7001);
        chk("t7_err", 32'(err_overrun), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dram_read_arb.md
# dram_read_arb

Two-requester arbiter for the single DRAM read command channel (kick/busy/read_addr/read_num) and its return stream (buf_dout/buf_we). It sits between the DRAM read engine and its clients: port 0 is the HDMI line prefetcher, port 1 is a secondary reader such as UDP readback. It serialises whole read transactions, gives port 0 fixed priority with a starvation guard for port 1, and steers every returned beat to the owner of the current transaction.

## Interface
Parameters:
- STARVE_MAX, 4: number of consecutive port-0 grants allowed while port 1 is pending; range 1..15.

Ports:
- clk  in  1  system clock; the DRAM read engine runs in the same domain.
- rst  in  1  synchronous, active-high reset.
- m0_kick / m1_kick  in  1  one-cycle request pulse from the requester.
- m0_read_addr / m1_read_addr  in  32  byte address, sampled with the kick.
- m0_read_num / m1_read_num  in  32  beat count, sampled with the kick.
- m0_busy / m1_busy  out  1  requester's transaction is pending or in flight.
- m0_buf_dout / m1_buf_dout  out  32  returned data, registered.
- m0_buf_we / m1_buf_we  out  1  returned-data strobe, registered.
- kick  out  1  one-cycle pulse to the DRAM read engine.
- busy  in  1  DRAM read engine busy.
- read_addr  out  32  address to the engine; held from kick until the transaction completes.
- read_num  out  32  beat count to the engine; held the same way.
- buf_dout  in  32  data from the engine.
- buf_we  in  1  data strobe from the engine.
- grant  out  2  one-hot owner of the current transaction; 2'b00 when idle.
- err_overrun  out  1  sticky flag: the engine returned more beats than read_num.

## Operation
- Per-port pending register: mN_kick captures addr and num and sets pend_N. A kick is ignored while mN_busy=1.
- mN_busy = pend_N OR (grant[N] AND transaction not complete).
- States:
  - IDLE: if any pend_N, choose the winner, load read_addr/read_num, set grant, and clear pend_winner. Go to ISSUE, or to DONE if num==0.
  - ISSUE: drive kick=1 for exactly one cycle, then go to WAIT_BUSY.
  - WAIT_BUSY: stay until busy=1, then go to DATA.
  - DATA: stay until busy=0 and beat_cnt==read_num, then go to DONE.
  - DONE: one cycle. Drop the owner's mN_busy, set grant=0, return to IDLE.
- Arbitration:
  - Port 0 wins unless starve_cnt==STARVE_MAX and pend_1 is set.
  - starve_cnt increments on each port-0 grant made while pend_1 is set.
  - starve_cnt clears on any port-1 grant, and when port 0 is granted with pend_1 clear.
  - starve_cnt saturates at STARVE_MAX.
- Data steering:
  - Each buf_we beat goes to the current grant port, with one cycle of register latency. beat_cnt increments per beat.
  - Beats arriving when beat_cnt==read_num, or when grant==0, are dropped and set err_overrun.
- beat_cnt is 32-bit, clears in IDLE, and never wraps.

## Timing
- Reset values:
  - kick=0, grant=0, read_addr=0, read_num=0, all mN_busy=0, mN_buf_we=0, mN_buf_dout=0, err_overrun=0.
  - pend_N=0, starve_cnt=0, state=IDLE.
- Latencies:
  - mN_kick in cycle T gives mN_busy=1 at T+1 and kick=1 at T+2, provided the arbiter is idle.
  - Returned data: buf_we in cycle T gives mN_buf_we in cycle T+1.
  - DATA exit in cycle T gives mN_busy=0 at T+2 (DONE at T+1). The next transaction's kick comes no earlier than T+4.
- Simultaneous events:
  - m0_kick and m1_kick in the same cycle: both are latched, and arbitration follows the rules above.
  - A kick for port N in the same cycle as its DONE is ignored, because busy is still 1.
- busy falling before all beats arrive: the arbiter stays in DATA until the count completes.
- busy never asserting after kick: the arbiter waits forever. No timeout; the engine guarantees busy.
- Reset mid-transaction returns everything to its reset values within one cycle. In-flight beats arriving after reset are dropped without setting err_overrun, because err_overrun clears on reset and the drop rule applies only to grant==0 beats after the first IDLE cycle.

## Test plan
- Single port-0 read: m0_kick with addr 0x100 and num 4; the engine raises busy for 6 cycles and returns 4 beats. Required: kick at T+2 with read_addr=0x100 and read_num=4; 4 m0_buf_we pulses; m1_buf_we stays 0; m0_busy falls 2 cycles after busy falls; grant returns to 0.
- Simultaneous kicks: m0 (0x0, 2) and m1 (0x800, 2) in the same cycle. Required: port 0 served first, then port 1. m1_busy stays 1 throughout. Each port receives only its own 2 beats.
- Starvation with STARVE_MAX=4: port 1 pending while port 0 re-kicks immediately after each DONE. Required: grant order 0,0,0,0,1,0.
- Zero length: m1_kick with num 0. Required: no kick pulse; m1_busy high for exactly 2 cycles (pend, then DONE).
- Overrun: num 3 and the engine returns 4 beats. Required: 3 beats delivered, the 4th dropped, err_overrun=1 and held until rst.
- Reset in DATA after 1 of 4 beats. Required: next cycle grant=0 and busy outputs 0; a following m0_kick is served normally.
